wb_initiator_seq: RTL and testbench
===================================

# wb_initiator_seq

Wishbone initiator for the EOSS3 FPGA fabric: accepts register-access commands on a valid/ready port and issues them one at a time as single Wishbone cycles toward the FPGA IP address decoder. It returns read data and completion status on a valid/ready response port, and aborts unanswered cycles with an ACK timeout. It lets fabric-side logic access the timer controller, the reserved block, and other peripheral registers without the M4.

## Interface
- APERWIDTH, 17: Wishbone byte-address width.
- TIMEOUT_CYCLES, 16: bus cycles allowed without ACK before abort; legal range 2..2^TO_CNTR_WIDTH-1.
- TO_CNTR_WIDTH, 5: timeout counter width.
- DEFAULT_READ_VALUE, 32'hBAD_FAB_AC: RSP_DAT_o value on timeout.
- CMD_FIFO_DEPTH, 4: command FIFO depth, power of 2; used only with the FIFO macro.

Ports:
- WBs_CLK_i  in  1  single clock for all logic.
- WBs_RST_i  in  1  asynchronous, active-high reset.
- CMD_VALID_i  in  1  command valid.
- CMD_READY_o  out  1  command accepted when high together with CMD_VALID_i.
- CMD_WE_i  in  1  1=write, 0=read.
- CMD_ADR_i  in  APERWIDTH  byte address.
- CMD_BE_i  in  4  byte enables.
- CMD_DAT_i  in  32  write data.
- RSP_VALID_o  out  1  response valid.
- RSP_READY_i  in  1  response consumed when high together with RSP_VALID_o.
- RSP_DAT_o  out  32  read data; 0 for writes; DEFAULT_READ_VALUE on timeout.
- RSP_ERR_o  out  1  1 = ACK timeout.
- WBm_ADR_o  out  APERWIDTH  address.
- WBm_CYC_o, WBm_STB_o  out  1  cycle and strobe, always asserted together.
- WBm_WE_o  out  1  write enable.
- WBm_RD_o  out  1  read strobe, equal to CYC & ~WE.
- WBm_BYTE_STB_o  out  4  byte enables.
- WBm_DAT_o  out  32  write data.
- WBm_DAT_i  in  32  read data.
- WBm_ACK_i  in  1  acknowledge.
- BUSY_o  out  1  high when FSM not IDLE or a command is queued.

## Operation
- FSM states: IDLE, BUS, RESP.
- IDLE -> BUS when a command is available. Bus outputs load from that command.
- BUS: CYC, STB, ADR, WE, BYTE_STB and DAT are registered and held stable until the cycle ends. Timeout counter clears on entry and increments each cycle without ACK.
- BUS -> RESP on WBm_ACK_i=1:
  - Read: capture WBm_DAT_i into RSP_DAT_o.
  - Write: RSP_DAT_o=0.
  - RSP_ERR_o=0.
- BUS -> RESP on timeout (counter == TIMEOUT_CYCLES-1 with no ACK): RSP_DAT_o=DEFAULT_READ_VALUE, RSP_ERR_o=1.
- ACK in the same cycle as timeout: ACK wins.
- RESP: RSP_VALID_o=1, RSP_DAT_o and RSP_ERR_o held stable until RSP_READY_i=1.
  - On handshake: go to BUS if another command is queued, else IDLE.
- Exactly one outstanding bus cycle; no new cycle starts while a response is pending.
- ACK seen while not in BUS is ignored.
- Reset, including mid-cycle: every output goes to 0, the FIFO is flushed, and any in-flight cycle is abandoned with no response.

## Timing
- Command handshake at edge N -> CYC/STB high from cycle N+1 when idle.
- ACK sampled high at edge M -> CYC/STB low and RSP_VALID_o high from cycle M+1. Zero-wait-state slave gives 2 cycles from command to response.
- Timeout abort: CYC drops TIMEOUT_CYCLES cycles after rising.
- After a response handshake, the next queued command's CYC rises on the following cycle. There is at least 1 idle bus cycle between transfers.

## Configuration
- WB_INITIATOR_CMD_FIFO_EN defined:
  - Commands enter a CMD_FIFO_DEPTH-entry FIFO; CMD_READY_o = FIFO not full.
  - Commands are accepted in any state, including in the same cycle as a pop.
  - Order is preserved.
- Undefined:
  - Single holding register; CMD_READY_o=1 only in IDLE.
  - The command is loaded directly into the bus registers.
  - CMD_FIFO_DEPTH is ignored.

## Test plan
- Write 0x04004, BE=0xF, data 0x12345678, slave ACK after 2 waits -> WBm_* stable for 3 cycles, WE=1, RD=0; response ERR=0, DAT=0.
- Read 0x05FF0 with ACK and DAT_i=0x00010000 -> RD=1, RSP_DAT_o=0x00010000, ERR=0.
- Read 0x10000, ACK never returned -> CYC low after exactly 16 cycles; RSP_DAT_o=0xBADFABAC, ERR=1.
- ACK asserted on the timeout cycle -> ERR=0 and read data captured.
- FIFO build: push 5 commands back-to-back, RSP_READY_i held low -> CMD_READY_o low after 4 accepted (first already issued); responses in order; no second CYC while RSP_VALID_o pending.
- Assert WBs_RST_i mid-BUS -> CYC/STB/RSP_VALID_o/BUSY_o 0 immediately; no response after release.

Source files
------------

// File: rtl/wb_initiator_seq.sv
// Wishbone initiator: one single-cycle bus access per command, with ACK timeout and a valid/ready response port.
// Optional command FIFO: define WB_INITIATOR_CMD_FIFO_EN (default build uses a single direct-load slot).
module wb_initiator_seq #(
  parameter int unsigned APERWIDTH          = 17,
  parameter int unsigned TIMEOUT_CYCLES     = 16,
  parameter int unsigned TO_CNTR_WIDTH      = 5,
  parameter logic [31:0] DEFAULT_READ_VALUE = 32'hBADFABAC,
  parameter int unsigned CMD_FIFO_DEPTH     = 4
) (
  input  logic                 WBs_CLK_i,
  input  logic                 WBs_RST_i,
  input  logic                 CMD_VALID_i,
  output logic                 CMD_READY_o,
  input  logic                 CMD_WE_i,
  input  logic [APERWIDTH-1:0] CMD_ADR_i,
  input  logic [3:0]           CMD_BE_i,
  input  logic [31:0]          CMD_DAT_i,
  output logic                 RSP_VALID_o,
  input  logic                 RSP_READY_i,
  output logic [31:0]          RSP_DAT_o,
  output logic                 RSP_ERR_o,
  output logic [APERWIDTH-1:0] WBm_ADR_o,
  output logic                 WBm_CYC_o,
  output logic                 WBm_STB_o,
  output logic                 WBm_WE_o,
  output logic                 WBm_RD_o,
  output logic [3:0]           WBm_BYTE_STB_o,
  output logic [31:0]          WBm_DAT_o,
  input  logic [31:0]          WBm_DAT_i,
  input  logic                 WBm_ACK_i,
  output logic                 BUSY_o
);

  localparam int unsigned CMD_W = 1 + APERWIDTH + 4 + 32;
  localparam logic [TO_CNTR_WIDTH-1:0] TO_LAST = TO_CNTR_WIDTH'(TIMEOUT_CYCLES - 1);

  if ((TIMEOUT_CYCLES < 2) || (TIMEOUT_CYCLES > ((1 << TO_CNTR_WIDTH) - 1)) || (CMD_FIFO_DEPTH == 0))
  begin : g_param_chk
    $error("wb_initiator_seq: illegal TIMEOUT_CYCLES/TO_CNTR_WIDTH/CMD_FIFO_DEPTH");
  end

  typedef enum logic [1:0] {IDLE, BUS, RESP} state_t;

  state_t                   state;
  logic [TO_CNTR_WIDTH-1:0] to_cnt;

  logic                 cmd_fire;
  logic [CMD_W-1:0]     cmd_in;
  logic [CMD_W-1:0]     next_cmd;
  logic                 launch;
  logic                 queued_nxt;
  logic                 ready_nxt;
  logic                 nc_we;
  logic [APERWIDTH-1:0] nc_adr;
  logic [3:0]           nc_be;
  logic [31:0]          nc_dat;

  always_comb begin
    cmd_fire = CMD_VALID_i && CMD_READY_o;
    cmd_in   = {CMD_WE_i, CMD_ADR_i, CMD_BE_i, CMD_DAT_i};
  end

`ifdef WB_INITIATOR_CMD_FIFO_EN
  localparam int unsigned PTR_W = (CMD_FIFO_DEPTH > 1) ? $clog2(CMD_FIFO_DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(CMD_FIFO_DEPTH + 1);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(CMD_FIFO_DEPTH - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(CMD_FIFO_DEPTH);

  logic [CMD_W-1:0] fifo_mem [CMD_FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [CNT_W-1:0] fifo_cnt, fifo_cnt_nxt;
  logic             fifo_empty, bypass, fifo_push, fifo_pop;

  // An idle initiator with nothing queued sends the command straight to the bus registers.
  always_comb begin
    fifo_empty   = (fifo_cnt == '0);
    bypass       = cmd_fire && (state == IDLE) && fifo_empty;
    fifo_push    = cmd_fire && !bypass;
    fifo_pop     = !fifo_empty && ((state == IDLE) || ((state == RESP) && RSP_READY_i));
    fifo_cnt_nxt = fifo_cnt + CNT_W'(fifo_push) - CNT_W'(fifo_pop);
    launch       = bypass || fifo_pop;
    next_cmd     = bypass ? cmd_in : fifo_mem[rd_ptr];
    queued_nxt   = (fifo_cnt_nxt != '0);
    ready_nxt    = (fifo_cnt_nxt != CNT_FULL);
  end

  always_ff @(posedge WBs_CLK_i) begin
    if (fifo_push) fifo_mem[wr_ptr] <= cmd_in;
  end

  always_ff @(posedge WBs_CLK_i or posedge WBs_RST_i) begin
    if (WBs_RST_i) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
    end else begin
      if (fifo_push) wr_ptr <= (wr_ptr == PTR_LAST) ? '0 : wr_ptr + PTR_W'(1);
      if (fifo_pop)  rd_ptr <= (rd_ptr == PTR_LAST) ? '0 : rd_ptr + PTR_W'(1);
      fifo_cnt <= fifo_cnt_nxt;
    end
  end
`else
  // Ready is only raised in IDLE, so every accepted command launches immediately.
  always_comb begin
    launch     = cmd_fire;
    next_cmd   = cmd_in;
    queued_nxt = 1'b0;
    ready_nxt  = ((state == IDLE) && !launch) || ((state == RESP) && RSP_READY_i);
  end
`endif

  always_comb begin
    {nc_we, nc_adr, nc_be, nc_dat} = next_cmd;
  end

  always_ff @(posedge WBs_CLK_i or posedge WBs_RST_i) begin
    if (WBs_RST_i) begin
      state          <= IDLE;
      to_cnt         <= '0;
      CMD_READY_o    <= 1'b0;
      RSP_VALID_o    <= 1'b0;
      RSP_DAT_o      <= '0;
      RSP_ERR_o      <= 1'b0;
      WBm_ADR_o      <= '0;
      WBm_CYC_o      <= 1'b0;
      WBm_STB_o      <= 1'b0;
      WBm_WE_o       <= 1'b0;
      WBm_RD_o       <= 1'b0;
      WBm_BYTE_STB_o <= '0;
      WBm_DAT_o      <= '0;
      BUSY_o         <= 1'b0;
    end else begin
      CMD_READY_o <= ready_nxt;

      // Bus payload is loaded only at cycle start and held until the next launch.
      if (launch) begin
        to_cnt         <= '0;
        WBm_CYC_o      <= 1'b1;
        WBm_STB_o      <= 1'b1;
        WBm_WE_o       <= nc_we;
        WBm_RD_o       <= !nc_we;
        WBm_ADR_o      <= nc_adr;
        WBm_BYTE_STB_o <= nc_be;
        WBm_DAT_o      <= nc_dat;
      end

      case (state)
        IDLE: begin
          BUSY_o <= launch || queued_nxt;
          if (launch) state <= BUS;
        end

        BUS: begin
          BUSY_o <= 1'b1;
          if (WBm_ACK_i) begin
            WBm_CYC_o   <= 1'b0;
            WBm_STB_o   <= 1'b0;
            WBm_RD_o    <= 1'b0;
            RSP_VALID_o <= 1'b1;
            RSP_DAT_o   <= WBm_WE_o ? 32'h0 : WBm_DAT_i;
            RSP_ERR_o   <= 1'b0;
            state       <= RESP;
          end else if (to_cnt == TO_LAST) begin
            WBm_CYC_o   <= 1'b0;
            WBm_STB_o   <= 1'b0;
            WBm_RD_o    <= 1'b0;
            RSP_VALID_o <= 1'b1;
            RSP_DAT_o   <= DEFAULT_READ_VALUE;
            RSP_ERR_o   <= 1'b1;
            state       <= RESP;
          end else begin
            to_cnt <= to_cnt + TO_CNTR_WIDTH'(1);
          end
        end

        RESP: begin
          if (RSP_READY_i) begin
            RSP_VALID_o <= 1'b0;
            RSP_DAT_o   <= '0;
            RSP_ERR_o   <= 1'b0;
            BUSY_o      <= launch || queued_nxt;
            state       <= launch ? BUS : IDLE;
          end else begin
            BUSY_o <= 1'b1;
          end
        end

        default: begin
          state  <= IDLE;
          BUSY_o <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_wb_initiator_seq.sv
// Self-checking bench for wb_initiator_seq: directed test-plan cases plus randomized transfers vs a transaction model.
module tb_wb_initiator_seq;

  localparam int          TO  = 16;
  localparam logic [31:0] DEF = 32'hBADFABAC;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid, cmd_ready, cmd_we;
  logic [16:0] cmd_adr;
  logic [3:0]  cmd_be;
  logic [31:0] cmd_dat;
  logic        rsp_valid, rsp_ready, rsp_err;
  logic [31:0] rsp_dat;
  logic [16:0] wb_adr;
  logic        wb_cyc, wb_stb, wb_we, wb_rd, wb_ack, busy;
  logic [3:0]  wb_be;
  logic [31:0] wb_dat_o, wb_dat_i;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  wb_initiator_seq dut (
    .WBs_CLK_i      (clk),
    .WBs_RST_i      (rst),
    .CMD_VALID_i    (cmd_valid),
    .CMD_READY_o    (cmd_ready),
    .CMD_WE_i       (cmd_we),
    .CMD_ADR_i      (cmd_adr),
    .CMD_BE_i       (cmd_be),
    .CMD_DAT_i      (cmd_dat),
    .RSP_VALID_o    (rsp_valid),
    .RSP_READY_i    (rsp_ready),
    .RSP_DAT_o      (rsp_dat),
    .RSP_ERR_o      (rsp_err),
    .WBm_ADR_o      (wb_adr),
    .WBm_CYC_o      (wb_cyc),
    .WBm_STB_o      (wb_stb),
    .WBm_WE_o       (wb_we),
    .WBm_RD_o       (wb_rd),
    .WBm_BYTE_STB_o (wb_be),
    .WBm_DAT_o      (wb_dat_o),
    .WBm_DAT_i      (wb_dat_i),
    .WBm_ACK_i      (wb_ack),
    .BUSY_o         (busy)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One command through the bus; slave ACKs on bus cycle index wait_n (0-based), hold = cycles RSP_READY stays low.
  task automatic xfer(input logic we, input logic [16:0] adr, input logic [3:0] be,
                      input logic [31:0] dat, input int wait_n, input logic [31:0] rdat,
                      input int hold);
    int          cyc_n;
    int          exp_len;
    logic        exp_err;
    logic [31:0] exp_dat;
    if (wait_n < TO) begin
      exp_len = wait_n + 1;
      exp_err = 1'b0;
      exp_dat = we ? 32'h0 : rdat;
    end else begin
      exp_len = TO;
      exp_err = 1'b1;
      exp_dat = DEF;
    end
    for (int k = 0; k < 30 && !cmd_ready; k++) tick();
    chk("cmd_ready_idle", 64'(cmd_ready), 64'(1));
    cmd_valid = 1'b1;
    cmd_we    = we;
    cmd_adr   = adr;
    cmd_be    = be;
    cmd_dat   = dat;
    tick();
    cmd_valid = 1'b0;
    chk("cyc_rise", 64'({wb_cyc, wb_stb}), 64'(2'b11));
`ifndef WB_INITIATOR_CMD_FIFO_EN
    chk("cmd_ready_busy", 64'(cmd_ready), 64'(0));
`endif
    cyc_n = 0;
    while (wb_cyc && cyc_n < 40) begin
      chk("bus_fields", 64'({wb_stb, wb_adr, wb_we, wb_rd, wb_be, wb_dat_o, busy, rsp_valid}),
          64'({1'b1, adr, we, ~we, be, dat, 1'b1, 1'b0}));
      if (cyc_n == wait_n) begin
        wb_ack   = 1'b1;
        wb_dat_i = rdat;
      end else begin
        wb_ack   = 1'b0;
        wb_dat_i = $urandom;
      end
      tick();
      wb_ack = 1'b0;
      cyc_n++;
    end
    chk("cyc_len", 64'(cyc_n), 64'(exp_len));
    chk("rsp_valid_rise", 64'({rsp_valid, wb_stb}), 64'(2'b10));
    for (int h = 0; h < hold; h++) begin
      chk("rsp_hold", 64'({rsp_valid, rsp_err, rsp_dat, wb_cyc}), 64'({1'b1, exp_err, exp_dat, 1'b0}));
      tick();
    end
    chk("rsp_value", 64'({rsp_err, rsp_dat}), 64'({exp_err, exp_dat}));
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    chk("rsp_done", 64'({rsp_valid, wb_cyc, busy, cmd_ready}), 64'(4'b0001));
  endtask

  initial begin
    int          acc;
    int          n;
    logic        seen;
    logic [16:0] r_adr;
    logic [31:0] r_dat, r_rd;

    rst       = 1'b1;
    cmd_valid = 1'b0;
    cmd_we    = 1'b0;
    cmd_adr   = '0;
    cmd_be    = '0;
    cmd_dat   = '0;
    rsp_ready = 1'b0;
    wb_ack    = 1'b0;
    wb_dat_i  = '0;
    #1;
    chk("reset_outputs", 64'({cmd_ready, rsp_valid, rsp_err, rsp_dat, wb_cyc, wb_stb, wb_we, wb_rd, busy}), 64'(0));
    chk("reset_bus_vals", 64'({wb_adr, wb_be, wb_dat_o}), 64'(0));
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    tick();
    chk("ready_after_reset", 64'({cmd_ready, busy}), 64'(2'b10));

    // Write with 2 wait states, read with immediate ACK.
    xfer(1'b1, 17'h04004, 4'hF, 32'h12345678, 2, 32'hDEADBEEF, 2);
    xfer(1'b0, 17'h05FF0, 4'hF, 32'h0, 0, 32'h00010000, 0);
    // Read never ACKed, then ACK exactly on the timeout cycle.
    xfer(1'b0, 17'h10000, 4'hF, 32'h0, 1000, 32'h0, 1);
    xfer(1'b0, 17'h00040, 4'h3, 32'h0, TO - 1, 32'hCAFEF00D, 0);
    // ACK on the cycle just before the timeout cycle, and a write that times out.
    xfer(1'b0, 17'h00044, 4'h1, 32'h0, TO - 2, 32'h5A5A5A5A, 0);
    xfer(1'b1, 17'h1FFFC, 4'h8, 32'hFFFFFFFF, TO + 3, 32'h0, 0);

    // ACK while idle must be ignored.
    wb_ack   = 1'b1;
    wb_dat_i = 32'h11111111;
    tick();
    tick();
    wb_ack = 1'b0;
    chk("ack_in_idle", 64'({rsp_valid, wb_cyc, busy, cmd_ready}), 64'(4'b0001));

    for (int i = 0; i < 10; i++) begin
      r_adr = 17'($urandom);
      r_dat = $urandom;
      r_rd  = $urandom;
      xfer(1'($urandom_range(0, 1)), r_adr, 4'($urandom), r_dat, $urandom_range(0, 20), r_rd,
           $urandom_range(0, 3));
    end

`ifdef WB_INITIATOR_CMD_FIFO_EN
    // Five back-to-back reads: first launches, four fill the FIFO.
    acc = 0;
    for (int k = 0; k < 8; k++) begin
      if (acc < 5) begin
        cmd_valid = 1'b1;
        cmd_we    = 1'b0;
        cmd_adr   = 17'(32'h100 + 32'(acc) * 4);
        cmd_be    = 4'hF;
        cmd_dat   = '0;
      end else begin
        cmd_valid = 1'b0;
      end
      n = (cmd_valid && cmd_ready) ? 1 : 0;
      tick();
      acc += n;
    end
    cmd_valid = 1'b0;
    chk("fifo_accepted", 64'(acc), 64'(5));
    chk("fifo_full", 64'({cmd_ready, busy}), 64'(2'b01));
    for (int i = 0; i < 5; i++) begin
      n = 0;
      while (!wb_cyc && n < 30) begin
        tick();
        n++;
      end
      chk("fifo_cyc", 64'(wb_cyc), 64'(1));
      chk("fifo_adr", 64'(wb_adr), 64'(17'(32'h100 + 32'(i) * 4)));
      wb_ack   = 1'b1;
      wb_dat_i = 32'hA0000000 + 32'(i);
      tick();
      wb_ack = 1'b0;
      chk("fifo_rsp", 64'({rsp_valid, wb_cyc, rsp_err, rsp_dat}), 64'({1'b1, 1'b0, 1'b0, 32'hA0000000 + 32'(i)}));
      tick();
      tick();
      chk("fifo_no_cyc_pending", 64'({rsp_valid, wb_cyc}), 64'(2'b10));
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;
      chk("fifo_next_cyc", 64'({rsp_valid, wb_cyc}), 64'({1'b0, (i < 4)}));
    end
    chk("fifo_drained", 64'({busy, cmd_ready}), 64'(2'b01));
`endif

    // Reset in the middle of a bus cycle abandons it without a response.
    for (int k = 0; k < 30 && !cmd_ready; k++) tick();
    cmd_valid = 1'b1;
    cmd_we    = 1'b0;
    cmd_adr   = 17'h00100;
    cmd_be    = 4'hF;
    tick();
    cmd_valid = 1'b0;
    tick();
    tick();
    chk("pre_reset_bus", 64'({wb_cyc, busy}), 64'(2'b11));
    #2;
    rst = 1'b1;
    #1;
    chk("mid_reset", 64'({wb_cyc, wb_stb, rsp_valid, busy, cmd_ready}), 64'(0));
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst  = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 20; k++) begin
      wb_ack = 1'b1;
      tick();
      if (rsp_valid || wb_cyc || busy) seen = 1'b1;
    end
    wb_ack = 1'b0;
    chk("no_rsp_after_reset", 64'(seen), 64'(0));
    xfer(1'b0, 17'h00200, 4'hF, 32'h0, 1, 32'h600DD00D, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
